// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store data RAM responder with valid/ready request and response handshakes
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        fire;

    logic [31:0] mem [DEPTH];

    logic [29:0]      widx;
    logic [1:0]       lane;
    logic [IDX_W-1:0] ram_idx;
    logic             range_err;
    logic             fmt_err;
    logic             acc_err;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [3:0]       byte_en;
    logic [31:0]      wr_lanes;

    assign accept = req_valid && req_ready;
    assign fire   = (state == ACCESS) && (cnt == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ACCESS;
            ACCESS:  if (fire)      state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request is captured at acceptance so later changes on req_* are invisible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            write_q   <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                cnt      <= 4'(LATENCY - 1);
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || write_q) ? 32'd0 : load_data;
            end
        end
    end

    assign widx      = addr_q[31:2];
    assign lane      = addr_q[1:0];
    assign ram_idx   = widx[IDX_W-1:0];
    assign range_err = widx >= 30'(DEPTH);
    assign acc_err   = range_err || fmt_err;
    assign rd_word   = mem[ram_idx];
    assign rd_half   = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        fmt_err = 1'b0;
        case (funct3_q)
            3'b000:  fmt_err = 1'b0;
            3'b001:  fmt_err = addr_q[0];
            3'b010:  fmt_err = (lane != 2'b00);
            3'b100:  fmt_err = write_q;
            3'b101:  fmt_err = write_q || addr_q[0];
            default: fmt_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_comb begin
        load_data = 32'd0;
        case (funct3_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
    end

    // Store data is replicated across lanes; byte_en picks which lanes commit.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = wdata_q;
        case (funct3_q)
            3'b000: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                byte_en  = 4'b1111;
                wr_lanes = wdata_q;
            end
            default: begin
                byte_en  = 4'b0000;
                wr_lanes = wdata_q;
            end
        endcase
    end

    // A store landing on the same edge that reset rises must not commit.
    always_ff @(posedge clk) begin
        if (fire && write_q && !acc_err && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[ram_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_mis = 0;
    logic [32:0] exp_q [$];

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input int hold);
        int          cyc;
        logic [32:0] e;
        logic [31:0] held;
        exp_q.push_back({ee, er});
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = ~wd;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(LATENCY));
        e = exp_q.pop_front();
        check({tag, "_rdata"}, rsp_rdata, e[31:0]);
        check({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
        held = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            req_valid  = 1'b1;
            req_write  = 1'b1;
            req_funct3 = 3'b010;
            req_addr   = 32'h10;
            req_wdata  = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, held);
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_post_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_req("sw_dead", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        do_req("lw_dead", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        do_req("sw_zero10", 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, 0);
        do_req("sb_80", 1'b1, 3'b000, 32'h11, 32'h1234_5680, 32'h0, 1'b0, 0);
        do_req("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_8000, 1'b0, 0);
        do_req("lb_11", 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FF80, 1'b0, 0);
        do_req("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_0080, 1'b0, 0);
        do_req("sw_zero20", 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 0);
        do_req("sh_9abc", 1'b1, 3'b001, 32'h22, 32'h5555_9ABC, 32'h0, 1'b0, 0);
        do_req("lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_9ABC, 1'b0, 0);
        do_req("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_9ABC, 1'b0, 0);
        do_req("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h9ABC_0000, 1'b0, 0);

        do_req("err_lw_13", 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 0);
        do_req("err_sh_21", 1'b1, 3'b001, 32'h21, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        do_req("err_range", 1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1, 0);
        do_req("err_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        do_req("err_sbu", 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        do_req("lw_10_after_err", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_8000, 1'b0, 0);

        do_req("hold_lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h9ABC_0000, 1'b0, 5);
        do_req("lw_10_after_hold", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_8000, 1'b0, 0);

        do_req("sw_cafe", 1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h30;
        req_wdata  = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        do_req("lw_30_after_abort", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the Execute stage's load/store interface: a word-organised data RAM that services one byte, half or word request at a time.
- Stores use byte lanes. Loads return sign- or zero-extended data per funct3.
- Requests use a valid/ready handshake; responses are held until accepted.
- Sits between Execute (initiator) and the register writeback path.

Parameters:
- DEPTH, 1024, number of 32-bit words; byte address space is 4*DEPTH bytes.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept; a request is accepted when req_valid && req_ready on a rising edge.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- req_addr  input  32  byte address (rs1 + imm, computed by the initiator).
- req_wdata  input  32  store data; low byte, half or word is used.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load result; 0 for stores and for errors.
- rsp_err  output  1  request was misaligned, out of range or had an illegal funct3.

Behaviour:
- Reset (async): FSM to IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. RAM contents are not reset.
- State IDLE: req_ready=1. On acceptance:
  - latch write, funct3, addr and wdata;
  - load counter with LATENCY-1;
  - go to ACCESS.
- State ACCESS: req_ready=0. Counter decrements each cycle.
  - When the counter is 0, perform the access, register the result and go to RESP.
  - LATENCY=1 therefore gives rsp_valid on the cycle after acceptance.
- State RESP: rsp_valid=1 and outputs stable. When rsp_ready=1, drop rsp_valid next cycle and return to IDLE. req_ready=0 throughout RESP; no overlap or pipelining.
- Word index = addr[31:2]; lane = addr[1:0].
- Error conditions (any one sets rsp_err=1, rsp_rdata=0, and no RAM write occurs):
  - word index >= DEPTH;
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - funct3 not in {000,001,010,100,101};
  - store with funct3 100 or 101.
- Store B: writes only lane addr[1:0] with wdata[7:0]. Other bytes are unchanged.
- Store H: writes lanes {1,0} or {3,2} (selected by addr[1]) with wdata[15:0].
- Store W: writes the whole word.
- Load B/BU: selects byte addr[1:0]; B sign-extends bit 7, BU zero-extends.
- Load H/HU: selects half addr[1]; H sign-extends bit 15, HU zero-extends.
- Load W: returns the full word.
- Read-after-write: a load accepted after a store's response completes sees the stored data.
- Reset during ACCESS or RESP: the transaction is dropped, no response is issued, and the FSM returns to IDLE.
  - A store whose write edge coincides with reset assertion does not commit. The write happens only on the ACCESS-exit edge when reset is low.
- req_* inputs are ignored outside IDLE. Changes to req_wdata after acceptance have no effect.

Test Plan:
- Store W 0xDEADBEEF @0x10, then load W @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid exactly LATENCY cycles after each acceptance.
- Store B 0x80 @0x11 over word 0 -> load W @0x10 = 0x00008000; load B @0x11 = 0xFFFFFF80; load BU @0x11 = 0x00000080.
- Store H 0x9ABC @0x22 -> load H @0x22 = 0xFFFF9ABC, load HU = 0x00009ABC, load W @0x20 = 0x9ABC0000 (word previously 0).
- Load W @0x13, store H @0x21, load @4*DEPTH, funct3=011 -> each gives rsp_err=1, rsp_rdata=0; a following load W @0x10 shows memory unchanged.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, a second req_valid is not accepted. Release rsp_ready -> IDLE next cycle.
- Assert reset mid-ACCESS of store W 0x12345678 @0x30 -> rsp_valid=0, req_ready=1 immediately; a later load @0x30 returns the prior value.
